serial_parallel_cond: RTL and testbench
=======================================

Name: serial_parallel_cond

Overview:
Receive-side deserializer for the 1-bit serial lane driven by the team's parallel-to-serial transmitter (LSB first, one bit per CLK). It hunts for a comma symbol at bit granularity to find byte alignment. It declares the lane active after COMMA_COUNT consecutive aligned commas, then delivers 8-bit data bytes with a one-cycle valid strobe. It sits between the serial lane and the byte un-striping logic.

Parameters:
COMMA, 8'hBC, alignment/idle symbol.
COMMA_COUNT, 4, consecutive aligned commas required to enter ACTIVE (range 1..15).

Ports:
CLK  input  1  clock; all logic on posedge.
RESET  input  1  synchronous, active-high reset.
DATA_IN  input  1  serial bit, sampled every posedge CLK, LSB of each byte first.
DATA_OUT  output  8  last received data byte (registered).
VALID_OUT  output  1  one-cycle strobe: DATA_OUT updated with a non-comma byte.
ACTIVE  output  1  lane aligned and active.

Behaviour:
- Shift register SR[7:0]: every posedge, SR <= {DATA_IN, SR[7:1]}. Let NEXT = {DATA_IN, SR[7:1]}, the byte completed at this edge.
- RESET high at a posedge: SR=0, bit counter=0, comma counter=0, state=HUNT. DATA_OUT=8'h00, VALID_OUT=0, ACTIVE=0. RESET overrides everything, including mid-byte or while ACTIVE.
- States: HUNT, LOCK, ACTIVE (2-bit encoding).
- HUNT: compare NEXT==COMMA on every edge (bit-sliding search).
  - On a match: bit counter=0 and comma counter=1. If COMMA_COUNT==1, go to ACTIVE; otherwise go to LOCK.
  - On no match: stay in HUNT.
- LOCK: bit counter increments 0..7 and wraps. At the edge where the counter equals 7 (8th bit after the last comma), evaluate NEXT.
  - NEXT==COMMA: comma counter +1. If the new count equals COMMA_COUNT, go to ACTIVE; otherwise stay in LOCK.
  - NEXT!=COMMA: comma counter=0 and return to HUNT. Bit-level search resumes on the following edge; the failing byte is not re-searched.
- ACTIVE: ACTIVE=1, registered, asserted the cycle after the final qualifying comma edge. The bit counter keeps cycling 0..7. At each counter==7 edge:
  - DATA_OUT <= NEXT.
  - VALID_OUT <= (NEXT != COMMA).
  - A comma is idle: DATA_OUT is still updated, VALID_OUT stays 0.
- VALID_OUT is high for exactly one cycle per data byte, i.e. at most 1 cycle in 8.
- Latency: the last bit of a byte sampled at edge N gives DATA_OUT/VALID_OUT visible after edge N (before edge N+1).
- ACTIVE is sticky until RESET, or RESYNC when the optional feature is compiled in. A data byte matching no special pattern never drops alignment.
- Outside ACTIVE: VALID_OUT=0 and DATA_OUT holds its value.
- The comma counter saturates at COMMA_COUNT; the bit counter wraps 7->0.

Optional Feature:
Macro SERPAR_RESYNC_EN.
- Defined: extra input port RESYNC (1 bit), placed after RESET. RESYNC high at a posedge (with RESET low):
  - State goes to HUNT; bit counter and comma counter go to 0; ACTIVE=0 and VALID_OUT=0 next cycle.
  - SR keeps shifting normally. DATA_OUT holds.
  - A byte completing on the same edge is discarded (no VALID_OUT).
  - RESET has priority over RESYNC.
- Not defined: no RESYNC port; ACTIVE is left only via RESET.

Test Plan:
1. RESET held 3 cycles with DATA_IN=1 -> DATA_OUT=8'h00, VALID_OUT=0, ACTIVE=0 throughout and after release.
2. After reset, send 4x 8'hBC LSB-first, then 8'h5A, 8'hBC, 8'hC3.
   - ACTIVE=1 the cycle after the 32nd bit.
   - VALID_OUT pulses once with DATA_OUT=8'h5A.
   - The 8'hBC byte updates DATA_OUT with VALID_OUT=0.
   - VALID_OUT pulses with DATA_OUT=8'hC3.
3. Send 3 garbage bits (1,0,1), then 4x 8'hBC, then 8'h01 -> alignment found despite the offset; ACTIVE=1; one VALID_OUT with 8'h01.
4. Send 2x 8'hBC, 8'h77, 4x 8'hBC, 8'h12.
   - 8'h77 returns the FSM to HUNT with no ACTIVE.
   - Re-lock on the next 4 commas; VALID_OUT with 8'h12.
5. While ACTIVE, assert RESET in the middle of byte 8'hA5 (after bit 3) -> all outputs reset next cycle; no VALID_OUT for 8'hA5; re-lock requires 4 fresh commas.
6. SERPAR_RESYNC_EN defined: ACTIVE, pulse RESYNC one cycle mid-byte -> ACTIVE=0 next cycle; following data produces no VALID_OUT until 4 commas re-lock.

Source files
------------

// File: rtl/serial_parallel_cond_if.sv
// serial_parallel_cond_if: serial lane input and byte/status outputs of the receive deserializer.
interface serial_parallel_cond_if;
  logic       DATA_IN;
  logic [7:0] DATA_OUT;
  logic       VALID_OUT;
  logic       ACTIVE;
  modport master (output DATA_IN, input DATA_OUT, VALID_OUT, ACTIVE);
  modport slave (input DATA_IN, output DATA_OUT, VALID_OUT, ACTIVE);
endinterface

// File: rtl/serial_parallel_cond.sv
// serial_parallel_cond: LSB-first serial deserializer with bit-sliding comma alignment.
// Optional SERPAR_RESYNC_EN adds a RESYNC input that drops alignment back to HUNT.
module serial_parallel_cond #(
  parameter logic [7:0]  COMMA       = 8'hBC,
  parameter int unsigned COMMA_COUNT = 4
) (
  input logic CLK,
  input logic RESET,
`ifdef SERPAR_RESYNC_EN
  input logic RESYNC,
`endif
  serial_parallel_cond_if.slave lane
);
  typedef enum logic [1:0] {HUNT, LOCK, ACTIVE} state_t;
  localparam logic [3:0] CC = 4'(COMMA_COUNT);
  state_t     state;
  logic [7:0] sr, nxt;
  logic [2:0] bit_cnt;
  logic [3:0] comma_cnt;
  logic       is_comma, byte_end, resync;
`ifdef SERPAR_RESYNC_EN
  assign resync = RESYNC;
`else
  assign resync = 1'b0;
`endif
  assign nxt      = {lane.DATA_IN, sr[7:1]};
  assign is_comma = nxt == COMMA;
  assign byte_end = bit_cnt == 3'd7;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= HUNT;
      sr             <= '0;
      bit_cnt        <= '0;
      comma_cnt      <= '0;
      lane.DATA_OUT  <= '0;
      lane.VALID_OUT <= 1'b0;
      lane.ACTIVE    <= 1'b0;
    end else begin
      sr             <= nxt;
      lane.VALID_OUT <= 1'b0;
      if (resync) begin
        state       <= HUNT;
        bit_cnt     <= '0;
        comma_cnt   <= '0;
        lane.ACTIVE <= 1'b0;
      end else begin
        case (state)
          HUNT: if (is_comma) begin
            bit_cnt     <= '0;
            comma_cnt   <= 4'd1;
            state       <= CC == 4'd1 ? ACTIVE : LOCK;
            lane.ACTIVE <= CC == 4'd1;
          end
          LOCK: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_end) begin
              comma_cnt   <= is_comma ? comma_cnt + 4'd1 : 4'd0;
              state       <= !is_comma ? HUNT : comma_cnt + 4'd1 == CC ? ACTIVE : LOCK;
              lane.ACTIVE <= is_comma && comma_cnt + 4'd1 == CC;
            end
          end
          default: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_end) begin
              lane.DATA_OUT  <= nxt;
              lane.VALID_OUT <= !is_comma;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_serial_parallel_cond.sv
// tb_serial_parallel_cond: directed vectors for the comma-aligned serial deserializer.
module tb_serial_parallel_cond;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   valid_cnt = 0;
  serial_parallel_cond_if bus ();
`ifdef SERPAR_RESYNC_EN
  logic RESYNC = 1'b0;
  serial_parallel_cond dut (.CLK(CLK), .RESET(RESET), .RESYNC(RESYNC), .lane(bus));
`else
  serial_parallel_cond dut (.CLK(CLK), .RESET(RESET), .lane(bus));
`endif
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send_bit(input logic b);
    bus.DATA_IN = b;
    @(posedge CLK);
    #1;
    valid_cnt += int'(bus.VALID_OUT);
  endtask
  task automatic rx(input string tag, input logic [7:0] v, input logic ev, input logic ea, input logic [7:0] ed);
    valid_cnt = 0;
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    check({tag, " valid_now"}, 32'(bus.VALID_OUT), 32'(ev));
    check({tag, " valid_cnt"}, 32'(valid_cnt), 32'(ev));
    check({tag, " active"}, 32'(bus.ACTIVE), 32'(ea));
    check({tag, " data"}, 32'(bus.DATA_OUT), 32'(ed));
  endtask
  task automatic do_reset();
    RESET = 1'b1;
    send_bit(1'b1);
    RESET = 1'b0;
  endtask
  task automatic outs_zero(input string tag);
    check({tag, " data"}, 32'(bus.DATA_OUT), 32'h00);
    check({tag, " valid"}, 32'(bus.VALID_OUT), 32'h0);
    check({tag, " active"}, 32'(bus.ACTIVE), 32'h0);
  endtask
  initial begin
    bus.DATA_IN = 1'b1;
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b1);
      outs_zero("t1_reset");
    end
    RESET = 1'b0;
    outs_zero("t1_release");
    for (int i = 0; i < 3; i++) rx("t2_comma", 8'hBC, 1'b0, 1'b0, 8'h00);
    rx("t2_comma4", 8'hBC, 1'b0, 1'b1, 8'h00);
    rx("t2_5a", 8'h5A, 1'b1, 1'b1, 8'h5A);
    rx("t2_idle", 8'hBC, 1'b0, 1'b1, 8'hBC);
    rx("t2_c3", 8'hC3, 1'b1, 1'b1, 8'hC3);
    do_reset();
    outs_zero("t3_reset");
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 0; i < 3; i++) rx("t3_comma", 8'hBC, 1'b0, 1'b0, 8'h00);
    rx("t3_comma4", 8'hBC, 1'b0, 1'b1, 8'h00);
    rx("t3_01", 8'h01, 1'b1, 1'b1, 8'h01);
    do_reset();
    rx("t4_comma", 8'hBC, 1'b0, 1'b0, 8'h00);
    rx("t4_comma", 8'hBC, 1'b0, 1'b0, 8'h00);
    rx("t4_77", 8'h77, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) rx("t4_relock", 8'hBC, 1'b0, 1'b0, 8'h00);
    rx("t4_relock4", 8'hBC, 1'b0, 1'b1, 8'h00);
    rx("t4_12", 8'h12, 1'b1, 1'b1, 8'h12);
    valid_cnt = 0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    RESET = 1'b1;
    send_bit(1'b0);
    RESET = 1'b0;
    outs_zero("t5_midreset");
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("t5_a5_valid", 32'(valid_cnt), 32'h0);
    for (int i = 0; i < 3; i++) rx("t5_comma", 8'hBC, 1'b0, 1'b0, 8'h00);
    rx("t5_comma4", 8'hBC, 1'b0, 1'b1, 8'h00);
    rx("t5_3c", 8'h3C, 1'b1, 1'b1, 8'h3C);
`ifdef SERPAR_RESYNC_EN
    valid_cnt = 0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    RESYNC = 1'b1;
    send_bit(1'b0);
    RESYNC = 1'b0;
    check("t6_active", 32'(bus.ACTIVE), 32'h0);
    check("t6_valid", 32'(bus.VALID_OUT), 32'h0);
    check("t6_data", 32'(bus.DATA_OUT), 32'h3C);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    check("t6_66_valid", 32'(valid_cnt), 32'h0);
    for (int i = 0; i < 3; i++) rx("t6_comma", 8'hBC, 1'b0, 1'b0, 8'h3C);
    rx("t6_comma4", 8'hBC, 1'b0, 1'b1, 8'h3C);
    rx("t6_42", 8'h42, 1'b1, 1'b1, 8'h42);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
